vector_logical_pipe: RTL

VECTOR_LOGICAL_PIPE -- requirements
Module: vector_logical_pipe

---
 rtl/vector_pkg.sv | 28 ++
 rtl/vector_logical_lane.sv | 47 ++++
 rtl/vector_logical_pipe.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector logical pipe: opcodes, FSM states and
// the mask-condition codes carried in the low bits of the k register field.
package vector_pkg;

    localparam logic [6:0] OP_SCAL_AND = 7'h60;
    localparam logic [6:0] OP_VEC_AND  = 7'h61;
    localparam logic [6:0] OP_SCAL_OR  = 7'h62;
    localparam logic [6:0] OP_VEC_OR   = 7'h63;
    localparam logic [6:0] OP_SCAL_XOR = 7'h64;
    localparam logic [6:0] OP_VEC_XOR  = 7'h65;
    localparam logic [6:0] OP_SCAL_MRG = 7'h66;
    localparam logic [6:0] OP_VEC_MRG  = 7'h67;
    localparam logic [6:0] OP_MASK     = 7'h7D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        MC_ZERO    = 2'b00,
        MC_NONZERO = 2'b01,
        MC_POS     = 2'b10,
        MC_NEG     = 2'b11
    } mask_cond_t;

endpackage

// File: rtl/vector_logical_lane.sv
// Combinational per-element datapath: logical/merge result and the mask
// value for the mask-generation opcode.
module vector_logical_lane
    import vector_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [6:0]       instr,
    input  logic             clear,
    input  logic [WIDTH-1:0] sj,
    input  logic [WIDTH-1:0] vj,
    input  logic [WIDTH-1:0] vk,
    input  logic             m,
    input  mask_cond_t       cond,
    output logic [WIDTH-1:0] result,
    output logic             mv
);

    // Element result select; unknown opcodes and the mask opcode yield zero
    always_comb begin
        result = '0;
        case (instr)
            OP_SCAL_AND: result = sj & vk;
            OP_VEC_AND:  result = vj & vk;
            OP_SCAL_OR:  result = sj | vk;
            OP_VEC_OR:   result = vj | vk;
            OP_SCAL_XOR: result = sj ^ vk;
            OP_VEC_XOR:  result = clear ? '0 : (vj ^ vk);
            OP_SCAL_MRG: result = m ? sj : vk;
            OP_VEC_MRG:  result = m ? vj : vk;
            default:     result = '0;
        endcase
    end

    // Mask value chosen by the condition code
    always_comb begin
        mv = 1'b0;
        case (cond)
            MC_ZERO:    mv = (vj == '0);
            MC_NONZERO: mv = (vj != '0);
            MC_POS:     mv = ~vj[WIDTH-1];
            MC_NEG:     mv = vj[WIDTH-1];
            default:    mv = 1'b0;
        endcase
    end

endmodule

// File: rtl/vector_logical_pipe.sv
// Vector logical unit: latches an instruction, accepts vl elements, and
// returns each result LAT clocks later with its element index.
// Optional feature: define VLU_POPCNT_EN to build the final-mask popcount.
module vector_logical_pipe
    import vector_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int VLMAX = 64,
    parameter  int NREGS = 8,
    parameter  int LAT   = 2,
    localparam int RW    = $clog2(NREGS),
    localparam int EW    = $clog2(VLMAX),
    localparam int VW    = EW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [6:0]       i_instr,
    input  logic [RW-1:0]    i_i,
    input  logic [RW-1:0]    i_j,
    input  logic [RW-1:0]    i_k,
    input  logic [VW-1:0]    i_vl,
    input  logic [WIDTH-1:0] i_sj,
    input  logic [VLMAX-1:0] i_vm,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_vj,
    input  logic [WIDTH-1:0] i_vk,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [EW-1:0]    o_elem,
    output logic [VLMAX-1:0] o_mask,
    output logic             o_busy,
    output logic             o_done,
    output logic [VW-1:0]    o_popcnt
);

    state_t           state, state_nx;
    logic [6:0]       instr_q;
    logic [RW-1:0]    i_q, j_q, k_q;
    logic [VW-1:0]    vl_q, vl_eff;
    logic [WIDTH-1:0] sj_q;
    logic [EW-1:0]    cnt;
    logic             start_acc, accept, last_acc;
    logic [WIDTH-1:0] lane_res;
    logic             lane_mv;
    logic [RW+1:0]    k_ext;

    logic [LAT-1:0]   pv, plast;
    logic [WIDTH-1:0] pres [LAT];
    logic [EW-1:0]    pel  [LAT];

    assign start_acc = (state == ST_IDLE) && i_start;
    assign accept    = (state == ST_RUN) && i_valid;
    assign last_acc  = accept && ({1'b0, cnt} == vl_q - VW'(1));
    assign vl_eff    = ((i_vl == '0) || (i_vl > VW'(VLMAX))) ? VW'(VLMAX) : i_vl;
    assign k_ext     = {2'b00, k_q};

    assign o_valid  = pv[LAT-1];
    assign o_done   = pv[LAT-1] & plast[LAT-1];
    assign o_result = pres[LAT-1];
    assign o_elem   = pel[LAT-1];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state and busy decode
    always_comb begin
        state_nx = state;
        o_busy   = 1'b0;
        case (state)
            ST_IDLE:  if (i_start) state_nx = ST_RUN;
            ST_RUN: begin
                o_busy = 1'b1;
                if (last_acc) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (o_done) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Instruction latch and element counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            vl_q    <= '0;
            sj_q    <= '0;
            cnt     <= '0;
        end else if (start_acc) begin
            instr_q <= i_instr;
            i_q     <= i_i;
            j_q     <= i_j;
            k_q     <= i_k;
            vl_q    <= vl_eff;
            sj_q    <= (i_j == '0) ? '0 : i_sj;
            cnt     <= '0;
        end else if (accept) begin
            cnt     <= cnt + EW'(1);
        end
    end

    vector_logical_lane #(.WIDTH(WIDTH)) u_lane (
        .instr  (instr_q),
        .clear  ((i_q == j_q) && (j_q == k_q)),
        .sj     (sj_q),
        .vj     (i_vj),
        .vk     (i_vk),
        .m      (i_vm[EW'(VLMAX-1) - cnt]),
        .cond   (mask_cond_t'(k_ext[1:0])),
        .result (lane_res),
        .mv     (lane_mv)
    );

    // LAT-stage result pipeline; valid bits are the only state that matters on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv    <= '0;
            plast <= '0;
            for (int unsigned n = 0; n < LAT; n++) begin
                pres[n] <= '0;
                pel[n]  <= '0;
            end
        end else begin
            pv[0]    <= accept;
            plast[0] <= last_acc;
            pres[0]  <= lane_res;
            pel[0]   <= cnt;
            for (int unsigned n = 1; n < LAT; n++) begin
                pv[n]    <= pv[n-1];
                plast[n] <= plast[n-1];
                pres[n]  <= pres[n-1];
                pel[n]   <= pel[n-1];
            end
        end
    end

    // Mask register: cleared on start, written MSB-first at element acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_mask <= '0;
        end else if (start_acc) begin
            o_mask <= '0;
        end else if (accept && (instr_q == OP_MASK)) begin
            o_mask[EW'(VLMAX-1) - cnt] <= lane_mv;
        end
    end

`ifdef VLU_POPCNT_EN
    logic [VW-1:0] pc_sum;

    // Ones count of the current mask
    always_comb begin
        pc_sum = '0;
        for (int unsigned b = 0; b < VLMAX; b++) begin
            pc_sum = pc_sum + VW'(o_mask[b]);
        end
    end

    // Capture the final mask count when the instruction completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            o_popcnt <= '0;
        else if (start_acc) o_popcnt <= '0;
        else if (o_done)    o_popcnt <= pc_sum;
    end
`else
    assign o_popcnt = '0;
`endif

endmodule
